// File: rtl/fir_out_requant.sv
// Requantizer at the output of the 63-tap FIR: round, shift, saturate to 16 bits,
// then buffer in a first-word-fall-through FIFO delivered over valid/ready.
module fir_out_requant #(
   parameter int SHIFT = 8,
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ena,
   input  logic signed [31:0]        y_in,
   input  logic                      m_ready,
   input  logic                      clr_flags,
   output logic                      m_valid,
   output logic signed [15:0]        m_data,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      sat_flag,
   output logic [15:0]               drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic signed [32:0] RND      = 33'sd1 <<< (SHIFT - 1);
   localparam logic signed [32:0] MAX_V    = 33'sd32767;
   localparam logic signed [32:0] MIN_V    = -33'sd32768;
   localparam logic [AW:0]        FULL_LVL = (AW + 1)'(DEPTH);

   logic signed [32:0] sum;
   logic signed [32:0] r_q;
   logic               v1_q;
   logic signed [15:0] s2_d;
   logic               s2_sat;
   logic signed [15:0] s2_q;
   logic               push_q;

   logic signed [15:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic               pop;
   logic               full;
   logic               do_push;
   logic               drop;

   // 33-bit sum so the rounding constant can never overflow a full-scale input
   assign sum = $signed({y_in[31], y_in}) + RND;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      s2_d   = r_q[15:0];
      s2_sat = 1'b0;
      if (r_q > MAX_V) begin
         s2_d   = 16'sh7FFF;
         s2_sat = 1'b1;
      end else if (r_q < MIN_V) begin
         s2_d   = 16'sh8000;
         s2_sat = 1'b1;
      end
   end

   assign m_valid = (count != '0);
   assign m_data  = m_valid ? mem[rd_ptr] : '0;
   assign level   = count;
   assign pop     = m_valid & m_ready;
   assign full    = (count == FULL_LVL);
   assign do_push = push_q & (~full | pop);
   assign drop    = push_q & full & ~pop;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q      <= '0;
         v1_q     <= 1'b0;
         s2_q     <= '0;
         push_q   <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         sat_flag <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (ena)
            r_q <= sum >>> SHIFT;
         v1_q <= ena;
         if (v1_q)
            s2_q <= s2_d;
         push_q <= v1_q;

         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (clr_flags)
            sat_flag <= 1'b0;
         else if (v1_q && s2_sat)
            sat_flag <= 1'b1;

         if (clr_flags)
            drop_cnt <= '0;
         else if (drop && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= s2_q;
   end

endmodule

// File: tb/tb_fir_out_requant.sv
// Self-checking bench for fir_out_requant: directed cases plus randomized traffic
// compared every cycle against a queue-based model of the requantizer and FIFO.
module tb_fir_out_requant;

   localparam int SHIFT = 8;
   localparam int DEPTH = 8;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     ena = 1'b0;
   logic signed [31:0]       y_in = '0;
   logic                     m_ready = 1'b0;
   logic                     clr_flags = 1'b0;
   logic                     m_valid;
   logic signed [15:0]       m_data;
   logic [$clog2(DEPTH):0]   level;
   logic                     sat_flag;
   logic [15:0]              drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   fir_out_requant #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .y_in      (y_in),
      .m_ready   (m_ready),
      .clr_flags (clr_flags),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .level     (level),
      .sat_flag  (sat_flag),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Exact rounding: floor((y + 2^(S-1)) / 2^S) using integer division.
   function automatic longint requant(input longint y);
      longint d, num, q;
      d   = longint'(1) << SHIFT;
      num = y + d / 2;
      q   = num / d;
      if ((num % d != 0) && (num < 0))
         q = q - 1;
      return q;
   endfunction

   function automatic longint clamp16(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Model: two-slot delay line feeding a bounded queue.
   bit     st1_v, st2_v;
   longint st1_y, st2_d;
   longint fq[$];
   bit     m_sat;
   int     m_drop;

   always @(posedge clk) begin
      bit pop, accept, dropped, sat_evt;
      if (rst) begin
         st1_v = 0; st2_v = 0; st1_y = 0; st2_d = 0;
         fq.delete();
         m_sat = 0; m_drop = 0;
      end else begin
         pop     = (fq.size() != 0) && m_ready;
         accept  = st2_v && ((fq.size() < DEPTH) || pop);
         dropped = st2_v && !accept;
         if (pop) void'(fq.pop_front());
         if (accept) fq.push_back(st2_d);
         sat_evt = st1_v && (clamp16(requant(st1_y)) != requant(st1_y));
         if (clr_flags) begin
            m_sat = 0; m_drop = 0;
         end else begin
            if (sat_evt) m_sat = 1;
            if (dropped && m_drop < 65535) m_drop++;
         end
         st2_v = st1_v;
         if (st1_v) st2_d = clamp16(requant(st1_y));
         st1_v = ena;
         if (ena) st1_y = longint'(y_in);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_valid", longint'(m_valid), longint'(fq.size() != 0));
         check("level", longint'(level), longint'(fq.size()));
         check("m_data", longint'(m_data), (fq.size() != 0) ? fq[0] : 0);
         check("sat_flag", longint'(sat_flag), longint'(m_sat));
         check("drop_cnt", longint'(drop_cnt), longint'(m_drop));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; ena = 1'b0; clr_flags = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic one_shot(input logic signed [31:0] y, input longint exp, input string name);
      m_ready = 1'b1;
      ena = 1'b1; y_in = y;
      tick();
      ena = 1'b0;
      tick();
      check({name, "_early"}, longint'(m_valid), 0);
      tick();
      check({name, "_valid"}, longint'(m_valid), 1);
      check({name, "_data"}, longint'(m_data), exp);
      tick();
      check({name, "_gone"}, longint'(m_valid), 0);
   endtask

   initial begin
      tick();
      chk_en = 1'b1;
      check("rst_valid", longint'(m_valid), 0);
      check("rst_data", longint'(m_data), 0);
      check("rst_level", longint'(level), 0);
      rst = 1'b0;

      check("pin_rnd_384", requant(384), 2);
      check("pin_rnd_m129", requant(-129), -1);
      check("pin_clamp_max", clamp16(requant(32'sh7FFFFFFF)), 32767);

      // single sample and rounding cases
      one_shot(32'sd384, 2, "s384");
      check("s384_sat", longint'(sat_flag), 0);
      one_shot(-32'sd384, -1, "m384");
      one_shot(32'sd127, 0, "s127");
      one_shot(32'sd128, 1, "s128");
      one_shot(-32'sd129, -1, "m129");

      // saturation and flag clear
      one_shot(32'sh7FFFFFFF, 32767, "satp");
      check("satp_flag", longint'(sat_flag), 1);
      one_shot(32'sh80000000, -32768, "satn");
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check("clr_sat", longint'(sat_flag), 0);

      // overflow: 10 samples into an 8-deep FIFO with no pops
      do_reset();
      m_ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         ena = 1'b1; y_in = 256 * i;
         tick();
      end
      ena = 1'b0;
      tick(); tick();
      check("ovf_level", longint'(level), 8);
      check("ovf_drop", longint'(drop_cnt), 2);
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check("ovf_seq", longint'(m_data), i);
         tick();
      end
      check("ovf_empty", longint'(m_valid), 0);

      // full FIFO with simultaneous push and pop
      do_reset();
      m_ready = 1'b0;
      for (int c = 0; c < 28; c++) begin
         ena = 1'b1;
         y_in = int'($urandom_range(0, 65535)) * 64 - 2097152;
         m_ready = (c >= 10);
         tick();
         if (c >= 9) check("full_level", longint'(level), 8);
      end
      ena = 1'b0;
      check("full_drop", longint'(drop_cnt), 0);
      m_ready = 1'b1;
      repeat (12) tick();

      // reset mid-stream with level 5 and two samples in flight
      do_reset();
      m_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         ena = 1'b1; y_in = 512 * i;
         tick();
      end
      ena = 1'b0;
      tick(); tick();
      check("mid_level5", longint'(level), 5);
      for (int i = 6; i <= 7; i++) begin
         ena = 1'b1; y_in = 512 * i;
         tick();
      end
      rst = 1'b1; ena = 1'b0; m_ready = 1'b1;
      tick();
      check("mid_level0", longint'(level), 0);
      check("mid_valid0", longint'(m_valid), 0);
      check("mid_drop0", longint'(drop_cnt), 0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("mid_no_stale", longint'(m_valid), 0);
      end

      // randomized traffic in a low-ready and a high-ready phase
      for (int ph = 0; ph < 2; ph++) begin
         for (int c = 0; c < 250; c++) begin
            ena = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
               0: y_in = $urandom;
               1: y_in = int'($urandom_range(0, 65535)) - 32768;
               2: y_in = int'($urandom_range(0, 8388607)) - 4194304;
               default: y_in = $urandom_range(0, 1) ? 8388352 + int'($urandom_range(0, 256))
                                                    : -8388608 - int'($urandom_range(0, 256));
            endcase
            m_ready   = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr_flags = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 120) == 0);
            tick();
         end
      end

      rst = 1'b0; ena = 1'b0; clr_flags = 1'b0; m_ready = 1'b1;
      repeat (12) tick();
      check("drain_empty", longint'(m_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_out_requant.md
FIR_OUT_REQUANT -- requirements
Module: fir_out_requant

Purpose: receiving end of the 63-tap FIR output. Takes the 32-bit signed sample stream, then rounds, shifts, saturates to 16 bits, buffers, and delivers over valid/ready.

Interface
REQ-001 SHALL have parameter SHIFT, default 8: arithmetic right-shift applied to each input sample (legal 1..16).
REQ-002 SHALL have parameter DEPTH, default 8: output FIFO depth in entries (power of two, at least 2).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 ena  input  1  input sample strobe; y_in is valid in any cycle where ena=1.
REQ-007 y_in  input  32  signed filter output sample.
REQ-008 m_ready  input  1  downstream ready.
REQ-009 clr_flags  input  1  clears sat_flag and drop_cnt.
REQ-010 m_valid  output  1  m_data holds a valid sample.
REQ-011 m_data  output  16  signed requantized sample (FIFO head).
REQ-012 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 sat_flag  output  1  sticky flag: saturation has occurred.
REQ-014 drop_cnt  output  16  count of samples dropped on FIFO full, saturating at 0xFFFF.

Function
REQ-015 Stage 1 (the edge where ena=1) SHALL register r = (sext33(y_in) + 2^(SHIFT-1)) >>> SHIFT, rounding half toward +inf, with no 32-bit overflow.
REQ-016 Stage 2 (the next edge) SHALL clamp r to [-32768, 32767] and register it with a push strobe.
REQ-017 The clamp SHALL set sat_flag in the same edge as the stage-2 register whenever r is outside that range.
REQ-018 The push SHALL write the FIFO on the following edge; end-to-end latency is ena on edge k to m_valid=1 after edge k+2 when the FIFO is empty.
REQ-019 The pipeline SHALL accept ena=1 on every cycle (throughput 1 sample/clk); it has no back-pressure to the filter.
REQ-020 The FIFO SHALL be first-word-fall-through: m_data = head entry while m_valid = (level != 0).
REQ-021 A pop SHALL occur on an edge where m_valid=1 and m_ready=1.
REQ-022 m_data and m_valid SHALL NOT change while m_valid=1 and m_ready=0.
REQ-023 A push with the FIFO full and no pop on the same edge SHALL drop the sample, leave FIFO contents and level unchanged, and increment drop_cnt (saturating).
REQ-024 Simultaneous push and pop when full SHALL accept the push; level stays DEPTH and order is preserved.
REQ-025 Simultaneous push and pop when level=1 SHALL leave level=1, with the new sample at the head after the edge.
REQ-026 A push with the FIFO empty SHALL NOT present the sample until the following cycle (no bypass).
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 level SHALL be derived from a counter of width $clog2(DEPTH)+1, so full and empty are unambiguous.
REQ-029 clr_flags=1 SHALL zero sat_flag and drop_cnt on that edge; a saturation or drop event on the same edge loses to clr_flags.
REQ-030 ena=0 SHALL leave pipeline data registers unchanged and SHALL generate no push.

Reset
REQ-031 rst=1 at an edge SHALL clear pipeline registers, push strobe, FIFO pointers, level, sat_flag and drop_cnt to 0.
REQ-032 During and after reset, m_valid=0 and m_data=0.
REQ-033 rst SHALL override ena, m_ready and clr_flags in the same cycle.
REQ-034 Reset mid-stream SHALL discard all in-flight and buffered samples.
REQ-035 FIFO storage contents need not be reset.

Verification
REQ-036 SHIFT=8, m_ready=1, single ena with y_in=384 -> m_valid=1 for one cycle two edges later, m_data=2, sat_flag=0.
REQ-037 Rounding: y_in=-384 -> m_data=-1; y_in=127 -> 0; y_in=128 -> 1; y_in=-129 -> -1.
REQ-038 Saturation: y_in=0x7FFFFFFF -> m_data=32767 and sat_flag=1; y_in=0x80000000 -> m_data=-32768; clr_flags pulse -> sat_flag=0.
REQ-039 Overflow: m_ready=0, 10 consecutive ena with y_in=256*i (i=1..10) -> level=8, drop_cnt=2; then m_ready=1 -> m_data sequence 1..8, then m_valid=0.
REQ-040 Full with simultaneous push/pop: level=8, m_ready=1 and ena every cycle for 20 cycles -> drop_cnt=0, output order matches input order, level stays 8.
REQ-041 Reset mid-stream: assert rst with level=5 and two samples in flight -> next cycle level=0, m_valid=0, drop_cnt=0, and no stale sample emerges afterwards.
